// File: rtl/gpu_pkg.sv
// Shared core definitions: scheduler state codes, fetcher state encoding and
// program-memory width defaults used by the fetch unit and its cache.
package gpu_pkg;

  localparam int PROGRAM_MEM_ADDR_BITS_DEFAULT = 8;
  localparam int PROGRAM_MEM_DATA_BITS_DEFAULT = 16;

  localparam logic [2:0] CORE_IDLE = 3'b000;
  localparam logic [2:0] FETCH     = 3'b001;
  localparam logic [2:0] DECODE    = 3'b010;
  localparam logic [2:0] REQUEST   = 3'b011;
  localparam logic [2:0] WAIT      = 3'b100;
  localparam logic [2:0] EXECUTE   = 3'b101;
  localparam logic [2:0] UPDATE    = 3'b110;
  localparam logic [2:0] DONE      = 3'b111;

  typedef enum logic [2:0] {
    FETCHER_IDLE     = 3'b000,
    FETCHER_FETCHING = 3'b001,
    FETCHER_FETCHED  = 3'b010
  } fetcher_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/instruction_fetcher_if.sv
// Program-memory read channel: fetcher is the master, memory the slave.
interface instruction_fetcher_if #(
  parameter int ADDR_BITS = gpu_pkg::PROGRAM_MEM_ADDR_BITS_DEFAULT,
  parameter int DATA_BITS = gpu_pkg::PROGRAM_MEM_DATA_BITS_DEFAULT
);
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;

  modport master (output mem_read_valid, output mem_read_address,
                  input  mem_read_ready, input  mem_read_data);
  modport slave  (input  mem_read_valid, input  mem_read_address,
                  output mem_read_ready, output mem_read_data);
endinterface

// File: rtl/fetch_icache.sv
// Direct-mapped, one-instruction-per-line cache with combinational lookup and
// a synchronous fill port; reset clears every valid bit.
module fetch_icache #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int LINES     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] lookup_addr,
  output logic                 hit,
  output logic [DATA_BITS-1:0] hit_data,
  input  logic                 fill_en,
  input  logic [ADDR_BITS-1:0] fill_addr,
  input  logic [DATA_BITS-1:0] fill_data
);
  localparam int INDEX_BITS = $clog2(LINES);
  localparam int TAG_BITS   = ADDR_BITS - INDEX_BITS;

  logic [LINES-1:0]     valid_r;
  logic [TAG_BITS-1:0]  tag_r  [LINES];
  logic [DATA_BITS-1:0] data_r [LINES];

  logic [INDEX_BITS-1:0] lookup_idx_s;
  logic [TAG_BITS-1:0]   lookup_tag_s;
  logic [INDEX_BITS-1:0] fill_idx_s;
  logic [TAG_BITS-1:0]   fill_tag_s;

  assign lookup_idx_s = lookup_addr[INDEX_BITS-1:0];
  assign lookup_tag_s = lookup_addr[ADDR_BITS-1:INDEX_BITS];
  assign fill_idx_s   = fill_addr[INDEX_BITS-1:0];
  assign fill_tag_s   = fill_addr[ADDR_BITS-1:INDEX_BITS];

  assign hit      = valid_r[lookup_idx_s] && (tag_r[lookup_idx_s] == lookup_tag_s);
  assign hit_data = data_r[lookup_idx_s];

  // Valid bits: flushed by reset, set by a fill (aliases overwrite).
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= '0;
    end else if (fill_en) begin
      valid_r[fill_idx_s] <= 1'b1;
    end
  end

  // Tag and data storage needs no reset; valid guards it.
  always_ff @(posedge clk) begin
    if (fill_en && !reset) begin
      tag_r[fill_idx_s]  <= fill_tag_s;
      data_r[fill_idx_s] <= fill_data;
    end
  end

endmodule

// File: rtl/instruction_fetcher.sv
// Per-core instruction fetch unit: serves FETCH from the cache when possible,
// otherwise reads program memory, and reports IDLE/FETCHING/FETCHED.
module instruction_fetcher
  import gpu_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = PROGRAM_MEM_ADDR_BITS_DEFAULT,
  parameter int PROGRAM_MEM_DATA_BITS = PROGRAM_MEM_DATA_BITS_DEFAULT,
  parameter int CACHE_ENABLE          = 1,
  parameter int CACHE_LINES           = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  instruction_fetcher_if.master            mem,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [15:0]                      hit_count,
  output logic [15:0]                      miss_count
);
  fetcher_state_e state_r, state_n;
  logic                             valid_r, valid_n;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_r, addr_n;
  logic [PROGRAM_MEM_DATA_BITS-1:0] instr_r, instr_n;
  logic [15:0]                      hit_r, hit_n, miss_r, miss_n;
  logic                             cache_hit_s, lookup_hit_s, fill_en_s;
  logic [PROGRAM_MEM_DATA_BITS-1:0] cache_data_s;

  fetch_icache #(
    .ADDR_BITS(PROGRAM_MEM_ADDR_BITS),
    .DATA_BITS(PROGRAM_MEM_DATA_BITS),
    .LINES    (CACHE_LINES)
  ) u_icache (
    .clk        (clk),
    .reset      (reset),
    .lookup_addr(current_pc),
    .hit        (cache_hit_s),
    .hit_data   (cache_data_s),
    .fill_en    (fill_en_s),
    .fill_addr  (addr_r),
    .fill_data  (mem.mem_read_data)
  );

  assign lookup_hit_s = (CACHE_ENABLE != 0) && cache_hit_s;

  // Next-state and next-output logic for the fetch FSM and counters.
  always_comb begin
    state_n   = state_r;
    valid_n   = valid_r;
    addr_n    = addr_r;
    instr_n   = instr_r;
    hit_n     = hit_r;
    miss_n    = miss_r;
    fill_en_s = 1'b0;
    case (state_r)
      FETCHER_IDLE: begin
        if (core_state == FETCH) begin
          if (lookup_hit_s) begin
            instr_n = cache_data_s;
            hit_n   = sat_inc16(hit_r);
            state_n = FETCHER_FETCHED;
          end else begin
            valid_n = 1'b1;
            addr_n  = current_pc;
            miss_n  = sat_inc16(miss_r);
            state_n = FETCHER_FETCHING;
          end
        end else begin
          state_n = FETCHER_IDLE;
        end
      end
      FETCHER_FETCHING: begin
        if (mem.mem_read_ready) begin
          valid_n   = 1'b0;
          instr_n   = mem.mem_read_data;
          fill_en_s = (CACHE_ENABLE != 0);
          state_n   = FETCHER_FETCHED;
        end else begin
          state_n = FETCHER_FETCHING;
        end
      end
      FETCHER_FETCHED: begin
        if (core_state == DECODE) begin
          state_n = FETCHER_IDLE;
        end else begin
          state_n = FETCHER_FETCHED;
        end
      end
      default: begin
        state_n = FETCHER_IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCHER_IDLE;
      valid_r <= 1'b0;
      addr_r  <= '0;
      instr_r <= '0;
      hit_r   <= 16'd0;
      miss_r  <= 16'd0;
    end else begin
      state_r <= state_n;
      valid_r <= valid_n;
      addr_r  <= addr_n;
      instr_r <= instr_n;
      hit_r   <= hit_n;
      miss_r  <= miss_n;
    end
  end

  assign mem.mem_read_valid   = valid_r;
  assign mem.mem_read_address = addr_r;
  assign fetcher_state        = state_r;
  assign instruction          = instr_r;
  assign hit_count            = hit_r;
  assign miss_count           = miss_r;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Scoreboard bench: directed fetches on a cached (a) and an uncached (b) fetcher;
// expectations queue at issue, a negedge monitor checks each FETCHED entry.
module tb_instruction_fetcher;
  import gpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, rst_b = 1'b1;
  logic [2:0]  cs_a = 3'b000, cs_b = 3'b000;
  logic [7:0]  pc_a = 8'h00, pc_b = 8'h00;
  logic        rdy_a = 1'b0, rdy_b = 1'b0;
  logic [15:0] rdata_a = 16'h0000, rdata_b = 16'h0000;
  logic [2:0]  st_a, st_b;
  logic [15:0] instr_a, instr_b, hc_a, hc_b, mc_a, mc_b;

  instruction_fetcher_if ifa ();
  instruction_fetcher_if ifb ();
  assign ifa.mem_read_ready = rdy_a;
  assign ifa.mem_read_data  = rdata_a;
  assign ifb.mem_read_ready = rdy_b;
  assign ifb.mem_read_data  = rdata_b;

  instruction_fetcher #(.CACHE_ENABLE(1), .CACHE_LINES(8)) dut_a (
    .clk(clk), .reset(rst_a), .core_state(cs_a), .current_pc(pc_a), .mem(ifa.master),
    .fetcher_state(st_a), .instruction(instr_a), .hit_count(hc_a), .miss_count(mc_a));
  instruction_fetcher #(.CACHE_ENABLE(0), .CACHE_LINES(8)) dut_b (
    .clk(clk), .reset(rst_b), .core_state(cs_b), .current_pc(pc_b), .mem(ifb.master),
    .fetcher_state(st_b), .instruction(instr_b), .hit_count(hc_b), .miss_count(mc_b));

  typedef struct {
    int          dut;
    logic [15:0] ins;
    logic [15:0] h;
    logic [15:0] m;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int vcyc[2] = '{0, 0};
  int req[2]  = '{0, 0};
  logic [2:0] prev_st[2] = '{3'b000, 3'b000};
  logic       prev_vld[2] = '{1'b0, 1'b0};

  function automatic logic [2:0] f_st(input int d);
    return (d == 0) ? st_a : st_b;
  endfunction
  function automatic logic f_vld(input int d);
    return (d == 0) ? ifa.mem_read_valid : ifb.mem_read_valid;
  endfunction
  function automatic logic [7:0] f_addr(input int d);
    return (d == 0) ? ifa.mem_read_address : ifb.mem_read_address;
  endfunction
  function automatic logic [15:0] f_instr(input int d);
    return (d == 0) ? instr_a : instr_b;
  endfunction
  function automatic logic [15:0] f_hc(input int d);
    return (d == 0) ? hc_a : hc_b;
  endfunction
  function automatic logic [15:0] f_mc(input int d);
    return (d == 0) ? mc_a : mc_b;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s dut=%0d actual=%h required=%h t=%0t", nm, d, act, expv, $time);
    end
  endtask

  task automatic drive(input int d, input logic [2:0] c, input logic [7:0] p);
    if (d == 0) begin cs_a = c; pc_a = p; end
    else        begin cs_b = c; pc_b = p; end
  endtask
  task automatic drive_mem(input int d, input logic r, input logic [15:0] v);
    if (d == 0) begin rdy_a = r; rdata_a = v; end
    else        begin rdy_b = r; rdata_b = v; end
  endtask
  task automatic drive_rst(input int d, input logic r);
    if (d == 0) rst_a = r;
    else        rst_b = r;
  endtask

  // Monitor: counts request cycles and scores every entry into FETCHED.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (f_vld(d)) vcyc[d]++;
      if (f_vld(d) && !prev_vld[d]) req[d]++;
      if (f_st(d) == 3'b010 && prev_st[d] != 3'b010) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_fetched", d, 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_dut", d, d, e.dut);
          chk("sb_instruction", d, f_instr(d), e.ins);
          chk("sb_hit_count", d, f_hc(d), e.h);
          chk("sb_miss_count", d, f_mc(d), e.m);
        end
      end
      prev_st[d]  = f_st(d);
      prev_vld[d] = f_vld(d);
    end
  end

  task automatic do_reset(input int d);
    drive_rst(d, 1'b1);
    drive(d, CORE_IDLE, 8'h00);
    @(posedge clk); #1;
    drive_rst(d, 1'b0);
    chk("rst_state", d, f_st(d), 3'b000);
    chk("rst_valid", d, f_vld(d), 1'b0);
    chk("rst_addr", d, f_addr(d), 8'h00);
    chk("rst_instr", d, f_instr(d), 16'h0000);
    chk("rst_hits", d, f_hc(d), 16'h0000);
    chk("rst_misses", d, f_mc(d), 16'h0000);
  endtask

  task automatic fetch_miss(input int d, input logic [7:0] p, input logic [15:0] data,
                            input int lat, input logic [15:0] h, input logic [15:0] m);
    int v0, r0;
    v0 = vcyc[d];
    r0 = req[d];
    exp_q.push_back('{d, data, h, m});
    drive(d, FETCH, p);
    @(posedge clk); #1;
    for (int i = 1; i <= lat; i++) begin
      chk("req_valid", d, f_vld(d), 1'b1);
      chk("req_addr", d, f_addr(d), p);
      chk("state_fetching", d, f_st(d), 3'b001);
      if (i == lat) drive_mem(d, 1'b1, data);
      @(posedge clk); #1;
      drive_mem(d, 1'b0, 16'h0000);
    end
    chk("miss_fetched", d, f_st(d), 3'b010);
    chk("valid_dropped", d, f_vld(d), 1'b0);
    chk("valid_cycles", d, vcyc[d] - v0, lat);
    chk("request_count", d, req[d] - r0, 1);
  endtask

  task automatic fetch_hit(input int d, input logic [7:0] p, input logic [15:0] data,
                           input logic [15:0] h, input logic [15:0] m);
    exp_q.push_back('{d, data, h, m});
    drive(d, FETCH, p);
    @(posedge clk); #1;
    chk("hit_fetched_next_edge", d, f_st(d), 3'b010);
    chk("hit_no_request", d, f_vld(d), 1'b0);
  endtask

  task automatic to_decode(input int d, input logic [7:0] p);
    drive(d, DECODE, p);
    @(posedge clk); #1;
    chk("decode_to_idle", d, f_st(d), 3'b000);
    drive(d, CORE_IDLE, p);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset(0);
    do_reset(1);

    // cold miss then hit, then hold in FETCHED
    fetch_miss(0, 8'h05, 16'h3A7F, 2, 16'd0, 16'd1);
    to_decode(0, 8'h05);
    fetch_hit(0, 8'h05, 16'h3A7F, 16'd1, 16'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("hold_fetched", 0, f_st(0), 3'b010);
      chk("hold_no_request", 0, f_vld(0), 1'b0);
    end
    to_decode(0, 8'h05);

    // aliasing PCs 05 and 0D share line 5
    do_reset(0);
    fetch_miss(0, 8'h05, 16'h3A7F, 1, 16'd0, 16'd1);
    to_decode(0, 8'h05);
    fetch_miss(0, 8'h0D, 16'h1111, 1, 16'd0, 16'd2);
    to_decode(0, 8'h0D);
    fetch_miss(0, 8'h05, 16'h3A7F, 3, 16'd0, 16'd3);
    to_decode(0, 8'h05);
    fetch_hit(0, 8'h05, 16'h3A7F, 16'd1, 16'd3);
    to_decode(0, 8'h05);

    // reset while FETCHING with ready in the same cycle
    drive(0, FETCH, 8'h21);
    @(posedge clk); #1;
    chk("pre_reset_fetching", 0, f_st(0), 3'b001);
    drive_rst(0, 1'b1);
    drive_mem(0, 1'b1, 16'hBEEF);
    drive(0, CORE_IDLE, 8'h21);
    @(posedge clk); #1;
    drive_rst(0, 1'b0);
    drive_mem(0, 1'b0, 16'h0000);
    chk("midrst_valid", 0, f_vld(0), 1'b0);
    chk("midrst_state", 0, f_st(0), 3'b000);
    chk("midrst_instr", 0, f_instr(0), 16'h0000);
    chk("midrst_misses", 0, f_mc(0), 16'h0000);
    fetch_miss(0, 8'h05, 16'h2222, 1, 16'd0, 16'd1);
    to_decode(0, 8'h05);

    // stray ready while IDLE is ignored
    drive_mem(0, 1'b1, 16'hDEAD);
    @(posedge clk); #1;
    drive_mem(0, 1'b0, 16'h0000);
    chk("stray_ready_state", 0, f_st(0), 3'b000);
    chk("stray_ready_instr", 0, f_instr(0), 16'h2222);

    // cache disabled: repeated PC always goes to memory
    fetch_miss(1, 8'h05, 16'h3A7F, 2, 16'd0, 16'd1);
    to_decode(1, 8'h05);
    fetch_miss(1, 8'h05, 16'h3A7F, 1, 16'd0, 16'd2);
    to_decode(1, 8'h05);

    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", 0, exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/instruction_fetcher.md
Name: instruction_fetcher

Overview:
Per-core instruction fetch unit. It answers the core scheduler's FETCH state by returning the 16-bit instruction at current_pc and reporting progress on fetcher_state; the scheduler leaves FETCH only when it sees FETCHED. It is the program-memory initiator for the core and carries a small direct-mapped instruction cache, so loop bodies are served without a memory round trip.

Parameters:
PROGRAM_MEM_ADDR_BITS, 8, program address width; equals the current_pc width.
PROGRAM_MEM_DATA_BITS, 16, instruction width.
CACHE_ENABLE, 1, 1 = cache lookup and fill active; 0 = every fetch goes to memory.
CACHE_LINES, 8, number of one-instruction lines; a power of two, at least 2.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
core_state  in  3  scheduler state (FETCH=3'b001, DECODE=3'b010)
current_pc  in  8  address to fetch; stable while core_state==FETCH
mem_read_valid  out  1  program-memory read request
mem_read_address  out  8  request address
mem_read_ready  in  1  memory response strobe; data valid only in this cycle
mem_read_data  in  16  returned instruction
fetcher_state  out  3  IDLE=3'b000, FETCHING=3'b001, FETCHED=3'b010
instruction  out  16  fetched instruction; held until the next fetch completes
hit_count  out  16  saturating count of cache hits
miss_count  out  16  saturating count of memory fetches

Behaviour:
- Reset, synchronous and active-high. Next edge sets: fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0, hit_count=0, miss_count=0, all cache valid bits=0. This also applies mid-FETCHING: the request is dropped, and a mem_read_ready arriving in the reset cycle is ignored.
- Cache split: index = current_pc[log2(CACHE_LINES)-1:0], tag = remaining upper bits. Each line holds valid, tag and data.
- IDLE:
  - If core_state != FETCH, hold state.
  - If core_state == FETCH and the lookup hits (CACHE_ENABLE=1, valid, tag match): instruction<=line data, hit_count+1, fetcher_state<=FETCHED. The scheduler sees FETCHED one cycle after entering FETCH.
  - On a miss, or when CACHE_ENABLE=0: mem_read_valid<=1, mem_read_address<=current_pc, miss_count+1, fetcher_state<=FETCHING.
- FETCHING:
  - mem_read_valid and mem_read_address are held stable until mem_read_ready.
  - mem_read_ready can arrive in the first FETCHING cycle.
  - On the ready cycle: mem_read_valid<=0, instruction<=mem_read_data, fill line[index] (valid=1, tag, data) if CACHE_ENABLE, fetcher_state<=FETCHED.
  - Miss latency is 1 + (cycles until ready) cycles.
- FETCHED:
  - Holds until core_state == DECODE, then moves to IDLE.
  - If core_state == FETCH, stay (scheduler has not yet advanced).
  - No new request is issued from FETCHED.
- Replacement: a fill overwrites the line unconditionally (aliasing PCs evict each other).
- Counters saturate at 16'hFFFF and never wrap.
- instruction changes only on a hit or a fill.
- mem_read_ready outside FETCHING is ignored.
- Program memory is read-only while a kernel runs, so no invalidate port exists; reset is the only flush.
- core_state values other than FETCH and DECODE have no effect in any state.

Decomposition:
- Shared package gpu_pkg:
  - core_state localparams: IDLE, FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE, DONE.
  - Fetcher state encodings: IDLE, FETCHING, FETCHED.
  - PROGRAM_MEM_ADDR_BITS and PROGRAM_MEM_DATA_BITS defaults.
- Sub-module fetch_icache:
  - Holds the valid, tag and data arrays.
  - Combinational lookup (hit, data).
  - Synchronous fill port; clears valid bits on reset.
- The FSM and counters live in instruction_fetcher.

Test Plan:
- Cold miss: reset, core_state=FETCH, pc=8'h05, ready 2 cycles after valid with data 16'h3A7F -> mem_read_valid=1 with address 8'h05 held for exactly 2 cycles; instruction=16'h3A7F; fetcher_state=FETCHED; miss_count=1.
- Hit after fill: core_state=DECODE then FETCH again at pc=8'h05 -> no mem_read_valid; FETCHED on the next edge; instruction=16'h3A7F; hit_count=1.
- Alias eviction (CACHE_LINES=8): fetch 8'h05, then 8'h0D (data 16'h1111), then 8'h05 -> three memory requests; miss_count=3; hit_count=0.
- Hold in FETCHED: keep core_state=FETCH 4 cycles after FETCHED -> state stays FETCHED with no request; core_state=DECODE -> IDLE on the next edge.
- Reset mid-fetch: assert reset while FETCHING with ready arriving the same cycle -> valid=0, state=IDLE, instruction=0; a following fetch of the same pc misses.
- CACHE_ENABLE=0: fetch pc=8'h05 twice -> two memory requests; hit_count=0; miss_count=2.
